poly_ram_arbiter: RTL

- Round-robin arbiter sharing one single-port coefficient RAM (1-cycle read latency) between the STP (writer), EVP (reader) and EVB (reader) firing-mode FSMs.
- Sits between those FSMs and the coefficient RAM inside the firing-state controller.
- Supports locked bursts, so a requester can keep ownership across a full coefficient sweep.

---
 rtl/poly_ram_arbiter_pkg.sv | 23 ++
 rtl/poly_ram_arbiter_pick.sv | 31 +++
 rtl/poly_ram_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/poly_ram_arbiter_pkg.sv
// Shared definitions for the firing-state controller RAM arbiters:
// requester indices, arbiter state encoding and a ceil-log2 helper.
package poly_ram_arbiter_pkg;

  localparam int REQ_STP = 0;
  localparam int REQ_EVP = 1;
  localparam int REQ_EVB = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Width needed to hold indices 0..value-1; never narrower than 1 bit.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/poly_ram_arbiter_pick.sv
// Combinational round-robin selector: picks the first set request bit
// scanning ptr, ptr+1, ... modulo N. Shared with the data-RAM arbiter.
module rr_priority_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic             any
);

  int w_idx;

  always_comb begin
    sel   = '0;
    any   = 1'b0;
    w_idx = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      for (int j = 0; j < N; j++) begin
        if (!any && (j == w_idx) && req[j]) begin
          sel[j] = 1'b1;
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/poly_ram_arbiter.sv
// Round-robin arbiter sharing the single-port coefficient RAM between the
// STP/EVP/EVB FSMs, with locked bursts. Optional watchdog: ARB_TIMEOUT_EN.
module poly_ram_arbiter
  import poly_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int word_size      = 16,
  parameter int addr_width     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*addr_width-1:0] addr,
  input  logic [NUM_REQ*word_size-1:0]  wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [word_size-1:0]          rdata,
  output logic [addr_width-1:0]         ram_addr,
  output logic [word_size-1:0]          ram_wdata,
  output logic                          ram_wr_en,
  output logic                          ram_rd_en,
  input  logic [word_size-1:0]          ram_rdata,
  output logic                          busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int PTR_W = log2(NUM_REQ);

  arb_state_e             r_state;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [NUM_REQ-1:0]     r_rvalid;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_owner;

  logic [NUM_REQ-1:0]     w_sel;
  logic                   w_any;
  logic [PTR_W-1:0]       w_sel_idx;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic                   w_own_req;
  logic                   w_own_lock;
  logic                   w_own_we;
  logic [addr_width-1:0]  w_addr;
  logic [word_size-1:0]   w_wdata;
  logic                   w_access;
  logic                   w_release;
  logic                   w_timeout;

  rr_priority_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .sel (w_sel),
    .any (w_any)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel[i]) w_sel_idx = PTR_W'(i);
    end
  end

  // Owner's request slice; addr/wdata follow the owner even when idle.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    w_own_we   = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PTR_W'(i)) begin
        w_own_req  = req[i];
        w_own_lock = lock[i];
        w_own_we   = we[i];
        w_addr     = addr[i*addr_width +: addr_width];
        w_wdata    = wdata[i*word_size +: word_size];
      end
    end
  end

  assign w_access  = (r_state == ARB_OWN) && w_own_req;
  assign w_release = (r_state == ARB_OWN) && (!w_own_lock || w_timeout);
  assign w_ptr_nxt = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ARB_IDLE;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_ptr    <= PTR_W'(REQ_STP);
      r_owner  <= PTR_W'(REQ_STP);
    end else begin
      // Return path is tagged with the reader, independent of later ownership.
      r_rvalid <= (w_access && !w_own_we) ? r_gnt : '0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_sel;
            r_owner <= w_sel_idx;
            r_state <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (w_release) begin
            r_gnt   <= '0;
            r_ptr   <= w_ptr_nxt;
            r_state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = log2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_idle_cnt;
  logic             r_timeout_err;

  // Fires on the TIMEOUT_CYCLES-th consecutive OWN cycle without an access.
  assign w_timeout = (r_state == ARB_OWN) && !w_access &&
                     ((int'(r_idle_cnt) + 1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ARB_OWN || w_access || w_release) r_idle_cnt <= '0;
      else                                             r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = ram_rdata;
  assign busy      = |r_gnt;
  assign ram_addr  = w_addr;
  assign ram_wdata = w_wdata;
  assign ram_wr_en = w_access && w_own_we;
  assign ram_rd_en = w_access && !w_own_we;

endmodule
